spi_seq_master: RTL and testbench

- Parametrised successor to the single-channel sensor SPI engine behind the host endpoints.
- Plays a host-loaded command list out over one MOSI line and captures N_MISO MISO lanes in parallel.
- Supports single-frame and continuous modes, with a graceful stop.
- Sits between the endpoint decode logic (wireins/trigins) and the sensor pins; feeds captured words to the FIFO/pipe path.

---
 rtl/spi_seq_pkg.sv | 31 +++
 rtl/spi_word_shifter.sv | 45 ++++
 rtl/spi_seq_master.sv | 196 +++++++++++++++++++
 tb/tb_spi_seq_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the sequenced SPI master.
// Defaults match the sensor front-end build.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCLK_HI,
      SCLK_LO,
      GAP
   } state_t;

   function automatic int word_period(
      input int word_w,
      input int half_per,
      input int cs_gap
   );
      return half_per + 2 * half_per * word_w + cs_gap;
   endfunction

   localparam int DEF_WORD_W    = 16;
   localparam int DEF_N_MISO    = 2;
   localparam int DEF_SEQ_DEPTH = 32;
   localparam int DEF_HALF_PER  = 2;
   localparam int DEF_CS_GAP    = 14;

   localparam int IDX_W = $clog2(DEF_SEQ_DEPTH);
   localparam int WORD_PERIOD =
      word_period(DEF_WORD_W, DEF_HALF_PER, DEF_CS_GAP);

endpackage

// File: rtl/spi_word_shifter.sv
// One outgoing command shift register plus one capture
// register per MISO lane; the FSM supplies all strobes.
module spi_word_shifter
   import spi_seq_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int N_MISO = DEF_N_MISO
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [WORD_W-1:0]        load_data,
   input  logic                     shift_out,
   input  logic                     sample,
   input  logic [N_MISO-1:0]        miso,
   output logic                     mosi,
   output logic [N_MISO*WORD_W-1:0] rx_word
);

   logic [WORD_W-1:0]             tx;
   logic [N_MISO-1:0][WORD_W-1:0] cap;

   // Zeros shift in behind the command so MOSI rests low in GAP.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx  <= '0;
         cap <= '0;
      end else begin
         if (load) begin
            tx <= load_data;
         end else if (shift_out) begin
            tx <= tx << 1;
         end
         if (sample) begin
            for (int k = 0; k < N_MISO; k++) begin
               cap[k] <= {cap[k][WORD_W-2:0], miso[k]};
            end
         end
      end
   end

   assign mosi    = tx[WORD_W-1];
   assign rx_word = cap;

endmodule

// File: rtl/spi_seq_master.sv
// Plays a host-loaded command list over MOSI and captures
// N_MISO response lanes per word, single-shot or looping.
module spi_seq_master
   import spi_seq_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int N_MISO    = DEF_N_MISO,
   parameter int SEQ_DEPTH = DEF_SEQ_DEPTH,
   parameter int HALF_PER  = DEF_HALF_PER,
   parameter int CS_GAP    = DEF_CS_GAP
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         continuous,
   input  logic [$clog2(SEQ_DEPTH):0]   seq_last,
   input  logic                         cmd_wr_en,
   input  logic [$clog2(SEQ_DEPTH)-1:0] cmd_wr_addr,
   input  logic [WORD_W-1:0]            cmd_wr_data,
   output logic                         cs_b,
   output logic                         sclk,
   output logic                         mosi,
   input  logic [N_MISO-1:0]            miso,
   output logic                         rx_valid,
   output logic [N_MISO*WORD_W-1:0]     rx_data,
   output logic [$clog2(SEQ_DEPTH)-1:0] rx_index,
   output logic                         frame_done,
   output logic                         busy
);

   localparam int AW      = $clog2(SEQ_DEPTH);
   localparam int CNT_MAX = (HALF_PER > CS_GAP) ? HALF_PER : CS_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int BW      = $clog2(WORD_W + 1);

   localparam logic [CW-1:0] HALF_END = CW'(HALF_PER - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(CS_GAP - 1);
   localparam logic [BW-1:0] BIT_TOP  = BW'(WORD_W - 1);
   localparam logic [AW:0]   MAX_IDX  = (AW + 1)'(SEQ_DEPTH - 1);

   function automatic logic [AW-1:0] clamp_last(
      input logic [AW:0] v
   );
      return (v > MAX_IDX) ? MAX_IDX[AW-1:0] : v[AW-1:0];
   endfunction

   state_t        state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bit_cnt;
   logic [AW-1:0] idx;
   logic [AW-1:0] last;
   logic          cont;
   logic          stop_pend;

   logic [WORD_W-1:0]        ram [SEQ_DEPTH];
   logic [AW-1:0]            rd_addr;
   logic [WORD_W-1:0]        rd_data;
   logic                     half_end;
   logic                     gap_end;
   logic                     stop_now;
   logic                     load;
   logic                     sample;
   logic [N_MISO*WORD_W-1:0] rx_word;

   always_ff @(posedge clk) begin
      if (cmd_wr_en) begin
         ram[cmd_wr_addr] <= cmd_wr_data;
      end
   end

   // Bypass so a write in the same cycle as the read is seen.
   assign rd_addr = (state == GAP && idx != last) ? idx + 1'b1 : '0;
   assign rd_data = (cmd_wr_en && cmd_wr_addr == rd_addr)
                  ? cmd_wr_data : ram[rd_addr];

   assign half_end = (cnt == HALF_END);
   assign gap_end  = (state == GAP) && (cnt == GAP_END);
   assign stop_now = stop_pend | stop;
   assign sample   = (state == SCLK_HI) && half_end;
   assign load     = ((state == IDLE) && start)
                   || (gap_end && !stop_now && (idx != last || cont));

   spi_word_shifter #(
      .WORD_W (WORD_W),
      .N_MISO (N_MISO)
   ) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (rd_data),
      .shift_out (sample),
      .sample    (sample),
      .miso      (miso),
      .mosi      (mosi),
      .rx_word   (rx_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         idx        <= '0;
         last       <= '0;
         cont       <= 1'b0;
         stop_pend  <= 1'b0;
         cs_b       <= 1'b1;
         sclk       <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_index   <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= cnt + 1'b1;
         if (stop && state != IDLE) begin
            stop_pend <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (start) begin
                  last  <= clamp_last(seq_last);
                  cont  <= continuous;
                  idx   <= '0;
                  cs_b  <= 1'b0;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (half_end) begin
                  cnt     <= '0;
                  bit_cnt <= BIT_TOP;
                  sclk    <= 1'b1;
                  state   <= SCLK_HI;
               end
            end
            SCLK_HI: begin
               if (half_end) begin
                  cnt   <= '0;
                  sclk  <= 1'b0;
                  state <= SCLK_LO;
               end
            end
            SCLK_LO: begin
               if (half_end) begin
                  cnt <= '0;
                  if (bit_cnt == '0) begin
                     cs_b       <= 1'b1;
                     rx_valid   <= 1'b1;
                     rx_data    <= rx_word;
                     rx_index   <= idx;
                     frame_done <= (idx == last);
                     state      <= GAP;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     sclk    <= 1'b1;
                     state   <= SCLK_HI;
                  end
               end
            end
            GAP: begin
               if (gap_end) begin
                  cnt <= '0;
                  if (stop_now) begin
                     stop_pend <= 1'b0;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else if (idx != last) begin
                     idx   <= idx + 1'b1;
                     cs_b  <= 1'b0;
                     state <= SETUP;
                  end else if (cont) begin
                     last  <= clamp_last(seq_last);
                     cont  <= continuous;
                     idx   <= '0;
                     cs_b  <= 1'b0;
                     state <= SETUP;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_seq_master.sv
// Directed bench for spi_seq_master with a mode-0 slave model:
// lane 0 echoes the previous command, lane 1 returns ~MOSI.
module tb_spi_seq_master;
   import spi_seq_pkg::*;

   localparam int W  = DEF_WORD_W;
   localparam int NM = DEF_N_MISO;
   localparam int AW = IDX_W;
   localparam int FIRST = WORD_PERIOD - DEF_CS_GAP;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            stop;
   logic            continuous;
   logic [AW:0]     seq_last;
   logic            cmd_wr_en;
   logic [AW-1:0]   cmd_wr_addr;
   logic [W-1:0]    cmd_wr_data;
   logic            cs_b;
   logic            sclk;
   logic            mosi;
   logic [NM-1:0]   miso;
   logic            rx_valid;
   logic [NM*W-1:0] rx_data;
   logic [AW-1:0]   rx_index;
   logic            frame_done;
   logic            busy;

   int asserts = 0;
   int errors  = 0;
   int cyc = 0;
   int last_rx_cyc = 0;

   logic [W-1:0] cmd_m [DEF_SEQ_DEPTH];
   logic [W-1:0] exp_prev = '0;
   logic [W-1:0] slv_out  = '0;
   logic [W-1:0] slv_in   = '0;
   logic [W-1:0] slv_prev = '0;
   logic [W-1:0] mosi_q [$];
   logic         tog_en = 1'b1;
   logic         tog = 1'b0;

   spi_seq_master dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .continuous  (continuous),
      .seq_last    (seq_last),
      .cmd_wr_en   (cmd_wr_en),
      .cmd_wr_addr (cmd_wr_addr),
      .cmd_wr_data (cmd_wr_data),
      .cs_b        (cs_b),
      .sclk        (sclk),
      .mosi        (mosi),
      .miso        (miso),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_index    (rx_index),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign miso = tog_en ? {tog, tog} : {~mosi, slv_out[W-1]};

   always @(negedge cs_b) begin
      slv_out = slv_prev;
      slv_in  = '0;
   end
   always @(negedge sclk) slv_out = slv_out << 1;
   always @(posedge sclk) slv_in = {slv_in[W-2:0], mosi};
   always @(posedge cs_b) begin
      if (!reset) begin
         slv_prev = slv_in;
         mosi_q.push_back(slv_in);
      end
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      asserts++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic wr_cmd(input int a, input logic [W-1:0] d);
      @(negedge clk);
      cmd_wr_en   = 1'b1;
      cmd_wr_addr = AW'(a);
      cmd_wr_data = d;
      cmd_m[a]    = d;
      @(negedge clk);
      cmd_wr_en   = 1'b0;
   endtask

   task automatic go(input logic [AW:0] l, input logic c,
                     input logic with_stop);
      @(negedge clk);
      seq_last    = l;
      continuous  = c;
      start       = 1'b1;
      stop        = with_stop;
      last_rx_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("busy_start", busy, 1);
   endtask

   task automatic wait_rx(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = rx_valid;
      end
   endtask

   task automatic check_word(input int ei, input logic efd,
                             input int egap);
      logic         ok;
      logic [W-1:0] inv;
      wait_rx(ok);
      check("rx_seen", ok, 1);
      if (ok) begin
         inv = ~cmd_m[ei];
         check("rx_index", rx_index, ei);
         check("frame_done", frame_done, efd);
         check("lane0", rx_data[W-1:0], exp_prev);
         check("lane1", rx_data[2*W-1:W], inv);
         check("cs_b_gap", cs_b, 1);
         check("period", cyc - last_rx_cyc, egap);
         check("mosi_seen", mosi_q.size(), 1);
         if (mosi_q.size() > 0) begin
            check("mosi_word", mosi_q.pop_front(), cmd_m[ei]);
         end
         exp_prev    = cmd_m[ei];
         last_rx_cyc = cyc;
      end
   endtask

   task automatic idle_check();
      repeat (DEF_CS_GAP - 1) @(negedge clk);
      check("busy_gap", busy, 1);
      @(negedge clk);
      check("busy_end", busy, 0);
      check("cs_b_idle", cs_b, 1);
   endtask

   task automatic quiet(input int n);
      int bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (!cs_b || rx_valid) bad++;
      end
      check("quiet", bad, 0);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      continuous  = 1'b0;
      seq_last    = '0;
      cmd_wr_en   = 1'b0;
      cmd_wr_addr = '0;
      cmd_wr_data = '0;

      repeat (5) begin
         @(negedge clk);
         tog = ~tog;
         check("rst_rx_valid", rx_valid, 0);
      end
      check("rst_cs_b", cs_b, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_index", rx_index, 0);
      check("rst_frame_done", frame_done, 0);
      @(negedge clk);
      reset  = 1'b0;
      tog_en = 1'b0;

      for (int i = 0; i < DEF_SEQ_DEPTH; i++) begin
         wr_cmd(i, 16'h1357 ^ 16'(i * 16'h0911));
      end
      wr_cmd(0, 16'hA001);
      wr_cmd(1, 16'h0002);
      wr_cmd(2, 16'hFFFF);
      wr_cmd(3, 16'h8000);

      go(3, 1'b0, 1'b0);
      check_word(0, 1'b0, FIRST);
      check_word(1, 1'b0, WORD_PERIOD);
      check_word(2, 1'b0, WORD_PERIOD);
      check_word(3, 1'b1, WORD_PERIOD);
      idle_check();
      quiet(40);

      go(3, 1'b0, 1'b1);
      check_word(0, 1'b0, FIRST);
      check_word(1, 1'b0, WORD_PERIOD);
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_word(2, 1'b0, WORD_PERIOD);
      check_word(3, 1'b1, WORD_PERIOD);
      idle_check();

      go(1, 1'b1, 1'b0);
      check_word(0, 1'b0, FIRST);
      check_word(1, 1'b1, WORD_PERIOD);
      check_word(0, 1'b0, WORD_PERIOD);
      check_word(1, 1'b1, WORD_PERIOD);
      repeat (40) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_word(0, 1'b0, WORD_PERIOD);
      idle_check();
      quiet(200);

      go(40, 1'b0, 1'b0);
      for (int i = 0; i < DEF_SEQ_DEPTH; i++) begin
         check_word(i, i == DEF_SEQ_DEPTH - 1,
                    (i == 0) ? FIRST : WORD_PERIOD);
      end
      idle_check();

      go(3, 1'b0, 1'b0);
      check_word(0, 1'b0, FIRST);
      repeat (16) @(negedge clk);
      check("sclk_hi_w1", sclk, 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cs_b", cs_b, 1);
      check("abort_sclk", sclk, 0);
      check("abort_mosi", mosi, 0);
      check("abort_busy", busy, 0);
      check("abort_rx_valid", rx_valid, 0);
      reset = 1'b0;
      quiet(100);
      go(3, 1'b0, 1'b0);
      check_word(0, 1'b0, FIRST);
      check_word(1, 1'b0, WORD_PERIOD);
      check_word(2, 1'b0, WORD_PERIOD);
      check_word(3, 1'b1, WORD_PERIOD);
      idle_check();

      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
